// File: rtl/factor_sequencer.sv
// ============================================================================
// Module   : factor_sequencer
// Brief    : Trial-division controller producing an 8-bit divisor bitmask.
//            Optional macro FACTOR_SEQ_ABORT_EN adds an 'abort' input.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module factor_sequencer #(
    parameter int DIV_FIRST = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] number,
`ifdef FACTOR_SEQ_ABORT_EN
    input  logic       abort,
`endif
    output logic       busy,
    output logic       done,
    output logic [7:0] factors,
    output logic [3:0] divisor
);

    localparam logic [3:0] c_div_first = 4'(DIV_FIRST);
    localparam logic [3:0] c_div_last  = 4'(DIV_FIRST + 7);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SUB  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_next;

    logic [7:0] r_opnd;
    logic [7:0] r_rem;
    logic [7:0] r_acc;
    logic [7:0] r_factors;
    logic [3:0] r_div;

    logic       w_abort;
    logic       w_rem_ge;
    logic       w_last;
    logic       w_hit;
    logic [2:0] w_idx;

`ifdef FACTOR_SEQ_ABORT_EN
    assign w_abort = abort && (r_state != ST_IDLE);
`else
    assign w_abort = 1'b0;
`endif

    assign w_rem_ge = (r_rem >= {4'b0000, r_div});
    assign w_last   = (r_div == c_div_last);
    assign w_hit    = (r_rem == 8'd0);
    assign w_idx    = 3'(r_div - c_div_first);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (w_abort) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (start) w_next = ST_LOAD;
                ST_LOAD: w_next = ST_SUB;
                ST_SUB:  if (!w_rem_ge) w_next = w_last ? ST_DONE : ST_LOAD;
                ST_DONE: w_next = ST_IDLE;
                default: w_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opnd    <= 8'd0;
            r_rem     <= 8'd0;
            r_acc     <= 8'd0;
            r_factors <= 8'd0;
            r_div     <= 4'd0;
        end else if (w_abort) begin
            r_acc <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_opnd <= number;
                        r_acc  <= 8'd0;
                        r_div  <= c_div_first;
                    end
                end
                ST_LOAD: r_rem <= r_opnd;
                ST_SUB: begin
                    if (w_rem_ge) begin
                        r_rem <= r_rem - {4'b0000, r_div};
                    end else begin
                        r_acc[w_idx] <= w_hit;
                        if (!w_last) r_div <= r_div + 4'd1;
                    end
                end
                ST_DONE: r_factors <= r_acc;
                default: ;
            endcase
        end
    end

    // During DONE the fresh accumulator is shown so done and factors coincide.
    assign busy    = (r_state != ST_IDLE);
    assign done    = (r_state == ST_DONE) && !w_abort;
    assign factors = done ? r_acc : r_factors;
    assign divisor = ((r_state == ST_LOAD) || (r_state == ST_SUB)) ? r_div : 4'd0;

endmodule

`default_nettype wire

// File: tb/tb_factor_sequencer.sv
// ============================================================================
// Module   : tb_factor_sequencer
// Brief    : Scoreboard bench for factor_sequencer (random + directed runs).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_factor_sequencer;

    localparam int DIV_FIRST = 2;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       start  = 1'b0;
    logic [7:0] number = 8'd0;
`ifdef FACTOR_SEQ_ABORT_EN
    logic       abort  = 1'b0;
`endif
    logic       busy;
    logic       done;
    logic [7:0] factors;
    logic [3:0] divisor;

    always #50 clk = ~clk;

    factor_sequencer #(.DIV_FIRST(DIV_FIRST)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .number  (number),
`ifdef FACTOR_SEQ_ABORT_EN
        .abort   (abort),
`endif
        .busy    (busy),
        .done    (done),
        .factors (factors),
        .divisor (divisor)
    );

    typedef struct {
        logic [7:0] fac;
        int         due;
    } exp_t;

    exp_t       sb[$];
    int         errors    = 0;
    int         checks    = 0;
    int         cyc       = 0;
    int         win_a     = 1;
    int         win_e     = 0;
    int         next_free = 0;
    logic [7:0] model_fac = 8'd0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] ref_factors(input int n);
        logic [7:0] f;
        for (int i = 0; i < 8; i++) f[i] = ((n % (DIV_FIRST + i)) == 0);
        return f;
    endfunction

    function automatic int ref_cycles(input int n);
        int s = 0;
        for (int i = 0; i < 8; i++) s += n / (DIV_FIRST + i) + 2;
        return s;
    endfunction

    task automatic check(input string nm, input bit ok, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     nm, act, act, exp, exp, cyc);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_busy",    busy == 1'b0,    busy,    0);
        check("rst_done",    done == 1'b0,    done,    0);
        check("rst_factors", factors == 8'd0, factors, 0);
        check("rst_divisor", divisor == 4'd0, divisor, 0);
    endtask

    // Issue one start at the earliest edge the model says the DUT is IDLE.
    task automatic launch(input logic [7:0] n, input bit keep, output int a);
        int s;
        @(posedge clk); #10;
        while (cyc + 1 < next_free) begin
            @(posedge clk); #10;
        end
        number = n;
        start  = 1'b1;
        a      = cyc + 1;
        s      = ref_cycles(int'(n));
        sb.push_back('{fac: ref_factors(int'(n)), due: a + s});
        win_a     = a;
        win_e     = a + s;
        next_free = a + s + 2;
        if (!keep) begin
            @(posedge clk); #10;
            start = 1'b0;
        end
    endtask

    always @(negedge clk) begin : mon
        bit   exp_busy;
        exp_t e;
        if (rst_n) begin
            exp_busy = (cyc >= win_a) && (cyc <= win_e);
            check("busy", busy == exp_busy, busy, exp_busy);
            if (!exp_busy)
                check("divisor_idle", divisor == 4'd0, divisor, 0);
            else if (cyc == win_a)
                check("divisor_first", divisor == 4'(DIV_FIRST), divisor, DIV_FIRST);
            if (done) begin
                if (sb.size() == 0) begin
                    check("spurious_done", 1'b0, 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("done_cycle", cyc == e.due, cyc, e.due);
                    check("factors", factors == e.fac, factors, e.fac);
                    model_fac = e.fac;
                end
            end else begin
                check("factors_hold", factors == model_fac, factors, model_fac);
            end
        end
    end

    initial begin : stim
        int a;
        int guard;
        #1;
        check_reset_outputs();
        repeat (3) @(posedge clk);
        #10 rst_n = 1'b1;
        next_free = cyc + 1;

        launch(8'd12, 1'b0, a);

        // Reset in the middle of a long first divisor.
        launch(8'd200, 1'b0, a);
        repeat (20) @(posedge clk);
        #10 rst_n = 1'b0;
        void'(sb.pop_back());
        win_a = 1; win_e = 0; model_fac = 8'd0;
        #1;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        #10 rst_n = 1'b1;
        next_free = cyc + 1;

        launch(8'd12,  1'b0, a);
        launch(8'd255, 1'b0, a);
        launch(8'd7,   1'b0, a);
        launch(8'd0,   1'b0, a);
        launch(8'd1,   1'b0, a);

        // Extra start pulse and operand change while busy must be ignored.
        launch(8'd48, 1'b0, a);
        repeat (5) @(posedge clk);
        #10 start = 1'b1; number = 8'd35;
        @(posedge clk);
        #10 start = 1'b0;

        // Start held high: second run begins after one IDLE cycle.
        launch(8'd6, 1'b1, a);
        launch(8'd8, 1'b0, a);

`ifdef FACTOR_SEQ_ABORT_EN
        launch(8'd100, 1'b0, a);
        while (cyc < a + 9) begin
            @(posedge clk); #10;
        end
        abort = 1'b1;
        void'(sb.pop_back());
        win_e     = a + 9;
        next_free = a + 11;
        @(posedge clk);
        #10 abort = 1'b0;
`endif

        for (int k = 0; k < 8; k++)
            launch(8'($urandom_range(0, 255)), (k < 7) ? 1'($urandom_range(0, 1)) : 1'b0, a);

        guard = 0;
        while (sb.size() != 0 && guard < 2000) begin
            @(posedge clk);
            guard++;
        end
        if (sb.size() != 0) check("drain_timeout", 1'b0, sb.size(), 0);
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
